// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Buffers accepted write-backs in order, retires the oldest when the port is free,
// and forwards pending values onto the two combinational read ports.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int AW    = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [AW-1:0]              wb_addr_i,
    input  logic [WIDTH-1:0]           wb_data_i,
    input  logic                       rf_busy_i,
    output logic                       rf_write_o,
    output logic [AW-1:0]              rf_addr3_o,
    output logic [WIDTH-1:0]           rf_data3_o,
    input  logic [AW-1:0]              rd_addr1_i,
    input  logic [AW-1:0]              rd_addr2_i,
    input  logic [WIDTH-1:0]           rf_data1_i,
    input  logic [WIDTH-1:0]           rf_data2_i,
    output logic [WIDTH-1:0]           data1_o,
    output logic [WIDTH-1:0]           data2_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push_s;
    logic pop_s;
    logic [WIDTH-1:0] data1_s;
    logic [WIDTH-1:0] data2_s;

    // Handshake and retire qualifiers; reset blocks both immediately.
    always_comb begin
        wb_ready_o = (count_q != CW'(DEPTH)) && !reset_i;
        rf_write_o = (count_q != {CW{1'b0}}) && !rf_busy_i && !reset_i;
        push_s     = wb_valid_i && wb_ready_o;
        pop_s      = rf_write_o;
    end

    // Head entry is always presented to the write port.
    always_comb begin
        rf_addr3_o = addr_q[head_q];
        rf_data3_o = data_q[head_q];
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Queue control state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            addr_q[tail_q] <= wb_addr_i;
            data_q[tail_q] <= wb_data_i;
        end
    end

    // Walk valid entries oldest-to-youngest so the youngest match wins.
    always_comb begin
        data1_s = rf_data1_i;
        data2_s = rf_data2_i;
        for (int i = 0; i < DEPTH; i++) begin
            data1_s = ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == rd_addr1_i))
                      ? data_q[head_q + PW'(i)] : data1_s;
            data2_s = ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == rd_addr2_i))
                      ? data_q[head_q + PW'(i)] : data2_s;
        end
    end

    assign data1_o = data1_s;
    assign data2_o = data2_s;
    assign count_o = count_q;

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue sitting between the datapath's write-back stage and the register file's single write port (`write`/`addr3`/`data3`). It accepts write-back requests through a valid/ready handshake and buffers up to DEPTH of them in order. It retires the oldest request to the register file whenever the write port is not claimed by another agent. It also forwards still-pending values onto the register file's two combinational read ports, so readers always see the newest architectural value.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- WIDTH, 16: data width.
- AW, 2: register address width.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all queue state immediately.
- wb_valid  in  1  write-back request present.
- wb_ready  out  1  queue can accept; a transfer occurs on a rising edge with wb_valid & wb_ready.
- wb_addr  in  AW  destination register.
- wb_data  in  WIDTH  value to write.
- rf_busy  in  1  write port claimed by another agent this cycle; no retirement.
- rf_write  out  1  drives register file `write`.
- rf_addr3  out  AW  drives register file `addr3`.
- rf_data3  out  WIDTH  drives register file `data3`.
- rd_addr1, rd_addr2  in  AW  read addresses, also fed to the register file `addr1`/`addr2`.
- rf_data1, rf_data2  in  WIDTH  raw register file read data.
- data1, data2  out  WIDTH  forwarded read data.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage is a circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Push: wb_valid & wb_ready at an edge writes {wb_addr, wb_data} at tail, then tail+1.
- Pop: rf_write at an edge means the register file captures the head entry, then head+1.
- rf_write = (count != 0) & !rf_busy & !reset.
- rf_addr3 and rf_data3 always show the head entry. Their value is don't-care when count = 0.
- wb_ready = (count != DEPTH) & !reset. There is no pass-through when full, even if a pop occurs in the same cycle.
- Push and pop at the same edge: count is unchanged and both pointers advance.
- Duplicate addresses in the queue are legal. Retirement is in order, so the last-accepted value wins in the register file.
- Forwarding (combinational):
  - data1 is the data of the youngest valid entry whose address equals rd_addr1; otherwise rf_data1. data2 works the same way with rd_addr2.
  - Valid entries are the count entries starting at head. Stale slots never match.
  - The head entry being retired this cycle still forwards, because the register file updates only at the edge.
  - A request presented on wb_* but not yet accepted is not forwarded.
- Reset (asserted at any time, including mid-drain):
  - head = tail = count = 0; rf_write = 0 and wb_ready = 0 while reset is high.
  - Pending entries are discarded and never written.
  - data1 and data2 follow rf_data1 and rf_data2.
  - Storage contents need not be cleared.

## Timing
- Accept at edge N: the entry is forwardable after edge N, and rf_write can assert in cycle N+1.
- Minimum write-back latency is 1 cycle: the register file is written at edge N+1 if rf_busy is low.
- Sustained throughput is one request per cycle when rf_busy stays low; count stays ≤ 1.
- rf_busy held high: the queue fills. wb_ready drops in the cycle after count reaches DEPTH.
- Forwarding paths are purely combinational from rd_addr*, rf_data*, and the queue state. There are no registered outputs besides the state.
- Reset deassertion: wb_ready = 1 in the first cycle after reset falls.

## Test plan
- Single write: after reset, push {2, 0xBEEF} with rf_busy=0 → rf_write=1, rf_addr3=2, rf_data3=0xBEEF in the next cycle; count returns to 0; data1=0xBEEF with rd_addr1=2 throughout.
- Fill/stall: rf_busy=1, push {0,0x1111},{1,0x2222},{2,0x3333},{3,0x4444} → count=4, wb_ready=0, rf_write=0. Release rf_busy → four writes in order on consecutive cycles, then wb_ready=1.
- Duplicate forwarding: rf_busy=1, push {1,0xAAAA} then {1,0xBBBB}; rd_addr2=1 → data2=0xBBBB. Release rf_busy → writes 0xAAAA then 0xBBBB.
- Simultaneous push/pop: at count=2, push at every edge with rf_busy=0 → count stays at 2; wrap-around past entry DEPTH-1 preserves order.
- Reset mid-drain: rf_busy=1, three entries queued; assert reset between edges → wb_ready=0, rf_write=0, count=0 immediately. After release, no stale writes occur and data1 equals rf_data1.
- Busy toggle: alternate rf_busy each cycle with continuous pushes → no entry is lost or duplicated; write order matches push order.
